// File: rtl/decode_pkg.sv
// decode_pkg: shared constants, scoreboard entry type and field-decode helpers
// for the 16-bit decode stage.
package decode_pkg;

   // ALU select encodings presented to execute
   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_SLL = 4'b1000;
   localparam logic [3:0] ALU_SLR = 4'b1001;
   localparam logic [3:0] ALU_SRL = 4'b1010;
   localparam logic [3:0] ALU_SRA = 4'b1011;
   localparam logic [3:0] ALU_IDT = 4'b1100;
   localparam logic [3:0] ALU_NON = 4'b1111;

   // Opcode classes: bits [15:14], and bits [15:11] inside the immediate class
   localparam logic [1:0] CLS_LD    = 2'b00;
   localparam logic [1:0] CLS_ST    = 2'b01;
   localparam logic [1:0] CLS_IMM   = 2'b10;
   localparam logic [1:0] CLS_ARITH = 2'b11;
   localparam logic [4:0] OPC_LI    = 5'b10000;
   localparam logic [4:0] OPC_ADDI  = 5'b10001;
   localparam logic [4:0] OPC_BR0   = 5'b10100;
   localparam logic [4:0] OPC_BR1   = 5'b10111;
   localparam logic [3:0] OP_CMP    = 4'b0101;
   localparam logic [3:0] OP_MOV    = 4'b0110;

   // One in-flight producer as seen by forwarding / load-use logic
   typedef struct packed {
      logic       v;
      logic [2:0] dst;
      logic       is_load;
   } sb_entry_t;

   function automatic logic writes_reg(input logic [15:0] instr);
      logic r;
      case (instr[15:14])
         CLS_ARITH: begin
            case (instr[7:4])
               4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
               4'b0110, 4'b1000, 4'b1001, 4'b1010, 4'b1011,
               4'b1100: r = 1'b1;
               default: r = 1'b0;
            endcase
         end
         CLS_LD:  r = 1'b1;
         CLS_ST:  r = 1'b0;
         default: r = (instr[15:11] == OPC_LI) || (instr[15:11] == OPC_ADDI);
      endcase
      return r;
   endfunction

   function automatic logic [2:0] dst_of(input logic [15:0] instr);
      logic [2:0] d;
      case (instr[15:14])
         CLS_ARITH: d = instr[10:8];
         CLS_LD:    d = instr[13:11];
         CLS_IMM:   d = ((instr[15:11] == OPC_LI) || (instr[15:11] == OPC_ADDI)) ? instr[10:8] : 3'b000;
         default:   d = 3'b000;
      endcase
      return d;
   endfunction

   function automatic logic uses_a(input logic [15:0] instr);
      logic u;
      case (instr[15:14])
         CLS_ARITH: u = (instr[7:4] <= 4'b0110) || (instr[7:4] == 4'b1101);
         CLS_ST:    u = 1'b1;
         default:   u = 1'b0;
      endcase
      return u;
   endfunction

   function automatic logic uses_b(input logic [15:0] instr);
      logic u;
      case (instr[15:14])
         CLS_ARITH: u = (instr[7:4] <= 4'b0101) ||
                        ((instr[7:4] >= 4'b1000) && (instr[7:4] <= 4'b1011));
         CLS_LD:    u = 1'b1;
         CLS_ST:    u = 1'b1;
         default:   u = (instr[15:11] == OPC_ADDI);
      endcase
      return u;
   endfunction

   function automatic logic [3:0] alu_sel_of(input logic [15:0] instr);
      logic [3:0] s;
      case (instr[15:14])
         CLS_ARITH: begin
            case (instr[7:4])
               ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
               ALU_SLL, ALU_SLR, ALU_SRL, ALU_SRA, ALU_IDT: s = instr[7:4];
               OP_CMP:  s = ALU_SUB;
               OP_MOV:  s = ALU_IDT;
               default: s = instr[7:4];
            endcase
         end
         CLS_LD, CLS_ST: s = ALU_ADD;
         default: begin
            case (instr[15:11])
               OPC_LI:                      s = ALU_IDT;
               OPC_ADDI, OPC_BR0, OPC_BR1:  s = ALU_ADD;
               default:                     s = ALU_NON;
            endcase
         end
      endcase
      return s;
   endfunction

endpackage

// File: rtl/decode_stage_fwd_scoreboard.sv
// fwd_scoreboard: history of recently issued destinations (hist[1] mirrors the
// output register) plus nearest-producer search for both source operands.
module fwd_scoreboard
   import decode_pkg::*;
#(
   parameter int FWD_DEPTH = 2,
   parameter int FWD_W     = $clog2(FWD_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_adv,
   input  logic             i_flush,
   input  sb_entry_t        i_push,
   input  logic [2:0]       i_src_a,
   input  logic             i_use_a,
   input  logic [2:0]       i_src_b,
   input  logic             i_use_b,
   output logic [FWD_W-1:0] o_fwd_a,
   output logic [FWD_W-1:0] o_fwd_b,
   output sb_entry_t        o_head
);

   sb_entry_t r_hist [1:FWD_DEPTH];

   // Shift history when the output register advances; a flush on a held output kills hist[1]
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 1; k <= FWD_DEPTH; k++) begin
            r_hist[k] <= '0;
         end
      end else if (i_adv) begin
         for (int k = FWD_DEPTH; k >= 2; k--) begin
            r_hist[k] <= r_hist[k-1];
         end
         r_hist[1] <= i_push;
      end else if (i_flush) begin
         r_hist[1].v <= 1'b0;
      end
   end

   // Priority search from the far end so the nearest matching producer is the last writer
   always_comb begin
      o_fwd_a = '0;
      o_fwd_b = '0;
      for (int k = FWD_DEPTH; k >= 1; k--) begin
         o_fwd_a = (i_use_a && r_hist[k].v && (r_hist[k].dst == i_src_a)) ? FWD_W'(k) : o_fwd_a;
         o_fwd_b = (i_use_b && r_hist[k].v && (r_hist[k].dst == i_src_b)) ? FWD_W'(k) : o_fwd_b;
      end
   end

   assign o_head = r_hist[1];

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered decode with valid/ready on both sides, forwarding
// selects over FWD_DEPTH producers and optional load-use stall.
// Optional feature macro: DECODE_LOAD_STALL_EN (load-use bubble insertion).
module decode_stage
   import decode_pkg::*;
#(
   parameter int FWD_DEPTH = 2,
   parameter int FWD_W     = $clog2(FWD_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_instr,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_instr,
   output logic             out_wr,
   output logic [2:0]       out_dst,
   output logic [3:0]       out_alu_sel,
   output logic             out_is_load,
   output logic [FWD_W-1:0] out_fwd_a,
   output logic [FWD_W-1:0] out_fwd_b,
   output logic             hazard_stall
);

   generate
      if (FWD_DEPTH < 1 || FWD_DEPTH > 4) begin : g_bad_depth
         $error("decode_stage: FWD_DEPTH must be within 1..4");
      end
`ifdef DECODE_LOAD_STALL_EN
      if (FWD_DEPTH < 2) begin : g_bad_stall_depth
         $error("decode_stage: load-use stall needs FWD_DEPTH >= 2");
      end
`endif
   endgenerate

   logic             r_out_valid;
   logic [15:0]      r_out_instr;
   logic             r_out_wr;
   logic [2:0]       r_out_dst;
   logic [3:0]       r_out_alu;
   logic             r_out_ld;
   logic [FWD_W-1:0] r_out_fwd_a;
   logic [FWD_W-1:0] r_out_fwd_b;

   logic             w_wr, w_ua, w_ub, w_is_ld, w_push_ld;
   logic [2:0]       w_dst;
   logic [3:0]       w_alu;
   logic             w_adv, w_hazard, w_in_ready, w_accept;
   logic [FWD_W-1:0] w_fwd_a, w_fwd_b;
   sb_entry_t        w_push, w_head;

   assign w_wr    = writes_reg(in_instr);
   assign w_dst   = dst_of(in_instr);
   assign w_ua    = uses_a(in_instr);
   assign w_ub    = uses_b(in_instr);
   assign w_alu   = alu_sel_of(in_instr);
   assign w_is_ld = (in_instr[15:14] == CLS_LD);

   assign w_adv = out_ready | ~r_out_valid;

`ifdef DECODE_LOAD_STALL_EN
   assign w_hazard  = in_valid & w_head.v & w_head.is_load &
                      ((w_ua & (w_head.dst == in_instr[13:11])) |
                       (w_ub & (w_head.dst == in_instr[10:8])));
   assign w_push_ld = w_is_ld;
`else
   logic w_unused_head;
   assign w_unused_head = ^w_head;
   assign w_hazard      = 1'b0;
   assign w_push_ld     = 1'b0;
`endif

   // Flush wins over acceptance; nothing is taken while reset is held
   assign w_in_ready = rst_n & w_adv & ~w_hazard & ~flush;
   assign w_accept   = in_valid & w_in_ready;

   assign w_push.v       = w_accept & w_wr;
   assign w_push.dst     = w_dst;
   assign w_push.is_load = w_accept & w_push_ld;

   fwd_scoreboard #(
      .FWD_DEPTH(FWD_DEPTH),
      .FWD_W    (FWD_W)
   ) u_sb (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_adv  (w_adv),
      .i_flush(flush),
      .i_push (w_push),
      .i_src_a(in_instr[13:11]),
      .i_use_a(w_ua),
      .i_src_b(in_instr[10:8]),
      .i_use_b(w_ub),
      .o_fwd_a(w_fwd_a),
      .o_fwd_b(w_fwd_b),
      .o_head (w_head)
   );

   // Output register: load on accept, bubble on idle advance, hold under back-pressure
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_instr <= 16'h0000;
         r_out_wr    <= 1'b0;
         r_out_dst   <= 3'b000;
         r_out_alu   <= ALU_NON;
         r_out_ld    <= 1'b0;
         r_out_fwd_a <= '0;
         r_out_fwd_b <= '0;
      end else if (w_adv) begin
         if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_instr <= in_instr;
            r_out_wr    <= w_wr;
            r_out_dst   <= w_dst;
            r_out_alu   <= w_alu;
            r_out_ld    <= w_is_ld;
            r_out_fwd_a <= w_fwd_a;
            r_out_fwd_b <= w_fwd_b;
         end else begin
            r_out_valid <= 1'b0;
         end
      end else if (flush) begin
         r_out_valid <= 1'b0;
      end
   end

   assign in_ready     = w_in_ready;
   assign hazard_stall = w_hazard;
   assign out_valid    = r_out_valid;
   assign out_instr    = r_out_instr;
   assign out_wr       = r_out_wr;
   assign out_dst      = r_out_dst;
   assign out_alu_sel  = r_out_alu;
   assign out_is_load  = r_out_ld;
   assign out_fwd_a    = r_out_fwd_a;
   assign out_fwd_b    = r_out_fwd_b;

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode stage for the 16-bit core. It sits between fetch and execute and adds three things to plain decoding: a valid/ready handshake on both sides, forwarding selection over a configurable window of in-flight producers, and load-use stall insertion. It owns a scoreboard of recently issued destination registers.

## Interface
- FWD_DEPTH, 2, forwarding window in producer distances; legal range 1–4.
- FWD_W, $clog2(FWD_DEPTH+1), width of the forwarding selects (derived; do not override).
- clk  in  1  clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts in_instr this cycle.
- in_instr  in  16  instruction word.
- flush  in  1  taken branch; kills the decoded instruction held in the stage.
- out_valid  out  1  decoded instruction available.
- out_ready  in  1  execute consumes the output this cycle.
- out_instr  out  16  registered copy of the instruction.
- out_wr  out  1  instruction writes the register file.
- out_dst  out  3  destination register.
- out_alu_sel  out  4  ALU select (ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 1000, SLR 1001, SRL 1010, SRA 1011, IDT 1100, NON 1111).
- out_is_load  out  1  instruction is LD.
- out_fwd_a, out_fwd_b  out  FWD_W  0 = register file; k = result of the producer k positions ahead.
- hazard_stall  out  1  a load-use bubble is being inserted this cycle.

## Operation
- Field use by class:
  - Arithmetic (bits [15:14]=11): rs=[13:11], rd=[10:8], op=[7:4].
  - LD (00): ra=[13:11], rb=[10:8].
  - ST (01): same fields as LD.
  - LI (10000), ADDI (10001): rb=[10:8].
- Writes:
  - Arithmetic ops 0000–0100, 0110, 1000–1011, 1100 write rd.
  - LD writes ra.
  - LI and ADDI write rb.
  - Everything else, including CMP (0101), has out_wr=0.
- Source A is rs. It is read by arithmetic ops 0000–0110 and 1101, and by ST.
- Source B is field [10:8]. It is read by arithmetic ops 0000–0101 and 1000–1011, by LD, by ST, and by ADDI.
- ALU select:
  - Arithmetic: CMP→SUB, MOV→IDT, otherwise op.
  - LD, ST, ADDI, branch 10100, branch 10111 → ADD.
  - LI → IDT.
  - Anything else → NON.
- Scoreboard: hist[1..FWD_DEPTH], each entry {v, dst, is_load}. hist[1] always describes the output register; an entry has v=1 only when its producer has out_wr=1.
- adv = out_ready | ~out_valid.
- On adv:
  - hist[k] ← hist[k-1].
  - hist[1] ← the newly loaded instruction, or an invalid bubble.
  - The output register loads a decoded instruction if in_valid & in_ready, else out_valid ← 0.
- When adv=0, the output register and the scoreboard hold.
- Forwarding select: out_fwd_x = smallest k with hist[k].v and hist[k].dst equal to the source; 0 if no match or the source is unused. Nearest producer wins.
- Load-use: hazard_stall = in_valid & a used source matches hist[1] with is_load=1.
- in_ready = rst_n & adv & ~hazard_stall & ~flush.
- flush: on the clock edge, out_valid ← 0 and hist[1].v ← 0. hist[2..] shift normally when adv. flush overrides acceptance.

## Timing
- Latency is one cycle from acceptance to out_valid.
- Full throughput (one per cycle) when out_ready=1 and there is no hazard.
- A load-use hazard costs exactly one bubble; the consumer then issues with fwd=2.
- While out_valid=1 and out_ready=0, every out_* is held stable.
- Reset values:
  - out_valid, out_wr, out_is_load = 0.
  - out_instr, out_dst, out_fwd_a, out_fwd_b = 0.
  - out_alu_sel = 1111.
  - All hist.v = 0.
  - in_ready = 0 while rst_n is low.
- Reset asserted mid-stall drops the held instruction; fetch must replay it.
- flush and hazard_stall in the same cycle: flush governs, and no instruction is accepted.

## Configuration
- DECODE_LOAD_STALL_EN:
  - Defined: load-use detection as above. Requires FWD_DEPTH≥2; elaborate an error otherwise.
  - Undefined: hazard_stall is tied to 0, is_load is ignored by the scoreboard, and software schedules load delay slots.

## Structure
- Package decode_pkg holds:
  - ALU select constants.
  - Opcode class constants (arithmetic, LD, ST, LI, ADDI, branches).
  - The scoreboard entry typedef.
  - Helper functions writes_reg(), dst_of(), uses_a(), uses_b().
- One natural sub-module: fwd_scoreboard. It holds hist, performs the shift, and does the nearest-match priority search for both sources.

## Test plan
- 0xD100 (ADD r1,r2) then 0xCB00 (ADD r3,r1), out_ready=1 → second instruction has out_fwd_a=1, out_fwd_b=0, out_dst=3, out_alu_sel=0000.
- 0xD100, 0xE400, 0xCB00 → third instruction has out_fwd_a=2.
- 0xD100, 0xE160 (MOV r1,r4), 0xCB00 → out_fwd_a=1 (nearest wins).
- 0xD150 (CMP) then 0xCB00 → out_wr=0 for CMP; out_fwd_a=0 for the consumer.
- 0x0A00 (LD r1,0(r2)) then 0xCB00 with the macro defined → hazard_stall=1 for one cycle, one bubble, then out_fwd_a=2. Without the macro: no bubble, out_fwd_a=1.
- Hold out_ready=0 for 3 cycles with 0xD100 held → out_* stable and in_ready=0. Then assert flush → out_valid=0 next cycle, and a following 0xCB00 gets out_fwd_a=0.
